// File: rtl/branch_resolve_if.sv
// Commit-to-resolve handshake plus the fetch/predictor feedback and counters
// produced by the branch resolve unit.
interface branch_resolve_if #(
    parameter int CNT_W = 32
);
    logic             commit_valid;
    logic             commit_ready;
    logic [31:0]      commit_pc;
    logic             commit_branch;
    logic             commit_jump;
    logic             commit_jalr;
    logic             commit_prediction;
    logic             commit_taken;
    logic [31:0]      commit_target;
    logic [31:0]      commit_jalr_address;
    logic [3:0]       commit_ras_ptr;
    logic             commit_exception;

    logic             update;
    logic             valid_in;
    logic [31:0]      committed_pc;
    logic [31:0]      pc_update;
    logic             mispredicted;
    logic [3:0]       flush_ptr;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport slave (
        input  commit_valid, commit_pc, commit_branch, commit_jump, commit_jalr,
               commit_prediction, commit_taken, commit_target, commit_jalr_address,
               commit_ras_ptr, commit_exception,
        output commit_ready, update, valid_in, committed_pc, pc_update,
               mispredicted, flush_ptr, branch_count, mispredict_count
    );

    modport master (
        output commit_valid, commit_pc, commit_branch, commit_jump, commit_jalr,
               commit_prediction, commit_taken, commit_target, commit_jalr_address,
               commit_ras_ptr, commit_exception,
        input  commit_ready, update, valid_in, committed_pc, pc_update,
               mispredicted, flush_ptr, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolve.sv
// Resolves committed control-flow instructions: detects mispredictions, drives
// the fetch redirect and predictor update, and blocks commit while fetch flushes.
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolve_if.slave  bus
);
    typedef enum logic {IDLE, FLUSH} state_t;

    state_t           r_state;
    logic [3:0]       r_flushCnt;
    logic             r_update;
    logic             r_validIn;
    logic [31:0]      r_committedPc;
    logic [31:0]      r_pcUpdate;
    logic             r_mispredicted;
    logic [3:0]       r_flushPtr;
    logic [CNT_W-1:0] r_branchCount;
    logic [CNT_W-1:0] r_mispredictCount;

    logic             w_ready;
    logic             w_hs;
    logic             w_isJalr;
    logic             w_isJump;
    logic             w_isBranch;
    logic             w_isCtrl;
    logic             w_live;
    logic             w_mispred;
    logic             w_taken;
    logic [31:0]      w_nextPc;

    assign w_ready    = (r_state == IDLE);
    assign w_hs       = bus.commit_valid && w_ready;

    // Class priority jalr > jump > branch when several flags are set.
    assign w_isJalr   = bus.commit_jalr;
    assign w_isJump   = bus.commit_jump && !bus.commit_jalr;
    assign w_isBranch = bus.commit_branch && !bus.commit_jump && !bus.commit_jalr;
    assign w_isCtrl   = w_isJalr || w_isJump || w_isBranch;

    // A trapping instruction still retires through the handshake but has no branch effect.
    assign w_live     = w_hs && !bus.commit_exception;

    assign w_mispred  = w_live &&
                        ((w_isJalr   && (bus.commit_target != bus.commit_jalr_address)) ||
                         (w_isBranch && (bus.commit_taken  != bus.commit_prediction)));

    assign w_taken    = w_isJalr || w_isJump || (w_isBranch && bus.commit_taken);
    assign w_nextPc   = w_taken ? bus.commit_target : (bus.commit_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= IDLE;
            r_flushCnt        <= '0;
            r_update          <= 1'b0;
            r_validIn         <= 1'b0;
            r_committedPc     <= '0;
            r_pcUpdate        <= '0;
            r_mispredicted    <= 1'b0;
            r_flushPtr        <= '0;
            r_branchCount     <= '0;
            r_mispredictCount <= '0;
        end else begin
            r_validIn      <= w_live && w_isBranch;
            r_mispredicted <= w_mispred;

            if (w_live && w_isBranch) begin
                r_update      <= bus.commit_taken;
                r_committedPc <= bus.commit_pc;
            end
            if (w_live && w_isCtrl) begin
                r_pcUpdate <= w_nextPc;
            end
            if (w_mispred) begin
                r_flushPtr <= bus.commit_ras_ptr;
            end

            if (w_live && w_isCtrl && (r_branchCount != '1)) begin
                r_branchCount <= r_branchCount + 1'b1;
            end
            if (w_mispred && (r_mispredictCount != '1)) begin
                r_mispredictCount <= r_mispredictCount + 1'b1;
            end

            // Commit stays blocked for FLUSH_CYCLES cycles after a redirect.
            case (r_state)
                IDLE: begin
                    if (w_mispred) begin
                        r_state    <= FLUSH;
                        r_flushCnt <= 4'(FLUSH_CYCLES);
                    end
                end
                FLUSH: begin
                    if (r_flushCnt <= 4'd1) begin
                        r_state    <= IDLE;
                        r_flushCnt <= '0;
                    end else begin
                        r_flushCnt <= r_flushCnt - 4'd1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_flushCnt <= '0;
                end
            endcase
        end
    end

    assign bus.commit_ready     = w_ready;
    assign bus.update           = r_update;
    assign bus.valid_in         = r_validIn;
    assign bus.committed_pc     = r_committedPc;
    assign bus.pc_update        = r_pcUpdate;
    assign bus.mispredicted     = r_mispredicted;
    assign bus.flush_ptr        = r_flushPtr;
    assign bus.branch_count     = r_branchCount;
    assign bus.mispredict_count = r_mispredictCount;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed, table-driven bench for branch_resolve, plus hand-written sequences
// for flush timing, reset interaction and counter saturation.
module tb_branch_resolve;
    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;

    branch_resolve_if #(.CNT_W(32)) bus  ();
    branch_resolve_if #(.CNT_W(4))  bus4 ();

    branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic        jmp;
        logic        jr;
        logic        pred;
        logic        tkn;
        logic [31:0] tgt;
        logic [31:0] jaddr;
        logic [3:0]  ras;
        logic        exc;
        logic        eValid;
        logic        eUpd;
        logic [31:0] eCpc;
        logic        eMis;
        logic [31:0] ePcu;
        logic [3:0]  eFptr;
        logic [31:0] eBc;
        logic [31:0] eMc;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        bus.commit_valid        = 1'b0;
        bus.commit_pc           = '0;
        bus.commit_branch       = 1'b0;
        bus.commit_jump         = 1'b0;
        bus.commit_jalr         = 1'b0;
        bus.commit_prediction   = 1'b0;
        bus.commit_taken        = 1'b0;
        bus.commit_target       = '0;
        bus.commit_jalr_address = '0;
        bus.commit_ras_ptr      = '0;
        bus.commit_exception    = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.commit_pc           = v.pc;
        bus.commit_branch       = v.br;
        bus.commit_jump         = v.jmp;
        bus.commit_jalr         = v.jr;
        bus.commit_prediction   = v.pred;
        bus.commit_taken        = v.tkn;
        bus.commit_target       = v.tgt;
        bus.commit_jalr_address = v.jaddr;
        bus.commit_ras_ptr      = v.ras;
        bus.commit_exception    = v.exc;
        bus.commit_valid        = 1'b1;
        @(posedge clk);
        #1;
        bus.commit_valid        = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"},    32'(bus.commit_ready), 32'd1);
        checkOutput({tag, "_update"},   32'(bus.update),       32'd0);
        checkOutput({tag, "_validIn"},  32'(bus.valid_in),     32'd0);
        checkOutput({tag, "_cpc"},      bus.committed_pc,      32'd0);
        checkOutput({tag, "_pcu"},      bus.pc_update,         32'd0);
        checkOutput({tag, "_mis"},      32'(bus.mispredicted), 32'd0);
        checkOutput({tag, "_fptr"},     32'(bus.flush_ptr),    32'd0);
        checkOutput({tag, "_bc"},       bus.branch_count,      32'd0);
        checkOutput({tag, "_mc"},       bus.mispredict_count,  32'd0);
    endtask

    task automatic waitReady4(input string tag);
        int n;
        n = 0;
        while (!bus4.commit_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus4.commit_ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: commit_ready still 0 after 20 cycles, expected 1", tag);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        clearInputs();
        bus4.commit_valid        = 1'b0;
        bus4.commit_pc           = 32'h40;
        bus4.commit_branch       = 1'b1;
        bus4.commit_jump         = 1'b0;
        bus4.commit_jalr         = 1'b0;
        bus4.commit_prediction   = 1'b1;
        bus4.commit_taken        = 1'b0;
        bus4.commit_target       = 32'h80;
        bus4.commit_jalr_address = '0;
        bus4.commit_ras_ptr      = 4'd6;
        bus4.commit_exception    = 1'b0;

        //           pc            br   jmp  jr   pred tkn  tgt           jaddr         ras   exc   vIn  upd  cpc           mis  pcu           fptr  bc     mc
        vecs[0]  = '{32'h00000100, 1'b1,1'b0,1'b0,1'b1,1'b1,32'h00000180, 32'h0,        4'd0, 1'b0, 1'b1,1'b1,32'h00000100, 1'b0,32'h00000180, 4'd0, 32'd1, 32'd0};
        vecs[1]  = '{32'h00000200, 1'b1,1'b0,1'b0,1'b1,1'b0,32'h00000280, 32'h0,        4'd5, 1'b0, 1'b1,1'b0,32'h00000200, 1'b1,32'h00000204, 4'd5, 32'd2, 32'd1};
        vecs[2]  = '{32'h00000300, 1'b0,1'b0,1'b1,1'b0,1'b0,32'h00000480, 32'h00000400, 4'd3, 1'b0, 1'b0,1'b0,32'h00000200, 1'b1,32'h00000480, 4'd3, 32'd3, 32'd2};
        vecs[3]  = '{32'h00000300, 1'b0,1'b0,1'b1,1'b0,1'b0,32'h00000480, 32'h00000480, 4'd7, 1'b0, 1'b0,1'b0,32'h00000200, 1'b0,32'h00000480, 4'd3, 32'd4, 32'd2};
        vecs[4]  = '{32'h00000500, 1'b0,1'b1,1'b0,1'b0,1'b0,32'h00000600, 32'h0,        4'd8, 1'b0, 1'b0,1'b0,32'h00000200, 1'b0,32'h00000600, 4'd3, 32'd5, 32'd2};
        vecs[5]  = '{32'h00000700, 1'b1,1'b0,1'b0,1'b1,1'b0,32'h00000780, 32'h0,        4'd9, 1'b1, 1'b0,1'b0,32'h00000200, 1'b0,32'h00000600, 4'd3, 32'd5, 32'd2};
        vecs[6]  = '{32'hFFFFFFFC, 1'b1,1'b0,1'b0,1'b1,1'b0,32'h00000010, 32'h0,        4'd1, 1'b0, 1'b1,1'b0,32'hFFFFFFFC, 1'b1,32'h00000000, 4'd1, 32'd6, 32'd3};
        vecs[7]  = '{32'h00000800, 1'b1,1'b1,1'b1,1'b0,1'b1,32'h00000900, 32'h00000900, 4'd2, 1'b0, 1'b0,1'b0,32'hFFFFFFFC, 1'b0,32'h00000900, 4'd1, 32'd7, 32'd3};
        vecs[8]  = '{32'h00000A00, 1'b1,1'b1,1'b0,1'b0,1'b0,32'h00000B00, 32'h0,        4'd4, 1'b0, 1'b0,1'b0,32'hFFFFFFFC, 1'b0,32'h00000B00, 4'd1, 32'd8, 32'd3};
        vecs[9]  = '{32'h00000C00, 1'b1,1'b0,1'b0,1'b0,1'b0,32'h00000D00, 32'h0,        4'd4, 1'b0, 1'b1,1'b0,32'h00000C00, 1'b0,32'h00000C04, 4'd1, 32'd9, 32'd3};
        vecs[10] = '{32'h00000E00, 1'b0,1'b0,1'b0,1'b1,1'b1,32'h00000F00, 32'h0,        4'd4, 1'b0, 1'b0,1'b0,32'h00000C00, 1'b0,32'h00000C04, 4'd1, 32'd9, 32'd3};

        doReset();
        checkAllZero("reset");

        for (int i = 0; i < 11; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            applyStimulus(vecs[i]);
            checkOutput({t, "_validIn"}, 32'(bus.valid_in),     32'(vecs[i].eValid));
            checkOutput({t, "_update"},  32'(bus.update),       32'(vecs[i].eUpd));
            checkOutput({t, "_cpc"},     bus.committed_pc,      vecs[i].eCpc);
            checkOutput({t, "_mis"},     32'(bus.mispredicted), 32'(vecs[i].eMis));
            checkOutput({t, "_pcu"},     bus.pc_update,         vecs[i].ePcu);
            checkOutput({t, "_fptr"},    32'(bus.flush_ptr),    32'(vecs[i].eFptr));
            checkOutput({t, "_bc"},      bus.branch_count,      vecs[i].eBc);
            checkOutput({t, "_mc"},      bus.mispredict_count,  vecs[i].eMc);
            checkOutput({t, "_ready0"},  32'(bus.commit_ready), vecs[i].eMis ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
            checkOutput({t, "_pulseV"},  32'(bus.valid_in),     32'd0);
            checkOutput({t, "_pulseM"},  32'(bus.mispredicted), 32'd0);
            checkOutput({t, "_ready1"},  32'(bus.commit_ready), vecs[i].eMis ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
            checkOutput({t, "_ready2"},  32'(bus.commit_ready), 32'd1);
        end

        // Back-to-back correctly predicted branches at full throughput.
        bus.commit_branch     = 1'b1;
        bus.commit_jump       = 1'b0;
        bus.commit_jalr       = 1'b0;
        bus.commit_exception  = 1'b0;
        bus.commit_prediction = 1'b1;
        bus.commit_taken      = 1'b1;
        bus.commit_valid      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.commit_pc     = 32'h1000 + 32'(k) * 32'h10;
            bus.commit_target = 32'h2000 + 32'(k) * 32'h10;
            @(posedge clk);
            #1;
            checkOutput($sformatf("b2b%0d_validIn", k), 32'(bus.valid_in), 32'd1);
            checkOutput($sformatf("b2b%0d_cpc", k),     bus.committed_pc,   32'h1000 + 32'(k) * 32'h10);
            checkOutput($sformatf("b2b%0d_bc", k),      bus.branch_count,   32'd10 + 32'(k));
            checkOutput($sformatf("b2b%0d_ready", k),   32'(bus.commit_ready), 32'd1);
        end
        bus.commit_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset one cycle into a flush aborts it.
        bus.commit_pc         = 32'h3000;
        bus.commit_prediction = 1'b0;
        bus.commit_taken      = 1'b1;
        bus.commit_target     = 32'h3100;
        bus.commit_ras_ptr    = 4'd11;
        bus.commit_valid      = 1'b1;
        @(posedge clk);
        #1;
        bus.commit_valid = 1'b0;
        checkOutput("rstflush_mis", 32'(bus.mispredicted), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkAllZero("rstflush");

        // A handshake coinciding with reset is discarded.
        bus.commit_pc         = 32'h5000;
        bus.commit_prediction = 1'b1;
        bus.commit_taken      = 1'b0;
        bus.commit_valid      = 1'b1;
        reset                 = 1'b1;
        @(posedge clk);
        #1;
        reset            = 1'b0;
        bus.commit_valid = 1'b0;
        @(posedge clk);
        #1;
        checkAllZero("rsths");

        // 20 mispredicted branches into a 4-bit counter instance.
        for (int k = 0; k < 20; k++) begin
            bus4.commit_valid = 1'b1;
            @(posedge clk);
            #1;
            bus4.commit_valid = 1'b0;
            waitReady4($sformatf("sat%0d_wait", k));
        end
        checkOutput("sat_bc", 32'(bus4.branch_count),     32'hF);
        checkOutput("sat_mc", 32'(bus4.mispredict_count), 32'hF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001: The module SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles commit is blocked after a misprediction (legal range 1-15).
REQ-002: The module SHALL have parameter CNT_W, default 32, giving the width of the performance counters.
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: commit_valid  input  1  a resolved control-flow instruction is presented by commit.
REQ-006: commit_ready  output  1  resolve unit accepts the presented instruction this cycle.
REQ-007: commit_pc  input  32  PC of the presented instruction.
REQ-008: commit_branch / commit_jump / commit_jalr  input  1 each  predecode class flags (conditional branch / JAL / JALR).
REQ-009: commit_prediction  input  1  taken prediction carried from fetch.
REQ-010: commit_taken  input  1  actual branch outcome.
REQ-011: commit_target  input  32  actual resolved target address.
REQ-012: commit_jalr_address  input  32  target predicted by fetch (RAS or redirect PC).
REQ-013: commit_ras_ptr  input  4  RAS pointer snapshot taken at fetch.
REQ-014: commit_exception  input  1  the presented instruction traps; branch handling is suppressed.
REQ-015: update  output  1  actual outcome bit for the history and predictor update.
REQ-016: valid_in  output  1  one-cycle pulse: a conditional branch committed.
REQ-017: committed_pc  output  32  PC used to index the predictor write.
REQ-018: pc_update  output  32  correct fetch PC after a misprediction.
REQ-019: mispredicted  output  1  one-cycle pulse requesting fetch redirect and RAS restore.
REQ-020: flush_ptr  output  4  RAS pointer to restore.
REQ-021: branch_count, mispredict_count  output  CNT_W each  saturating performance counters.

Function
REQ-022: A handshake SHALL occur when commit_valid && commit_ready; inputs are sampled only on a handshake.
REQ-023: All outputs except commit_ready SHALL be registered, appearing exactly 1 cycle after the handshake.
REQ-024: Non-handshake cycles SHALL drive valid_in=0 and mispredicted=0; update, committed_pc, pc_update and flush_ptr SHALL hold their last values.
REQ-025: On a handshake with commit_branch=1, valid_in=1, update=commit_taken and committed_pc=commit_pc.
REQ-026: A branch SHALL be mispredicted when commit_taken != commit_prediction.
REQ-027: A JALR SHALL be mispredicted when commit_target != commit_jalr_address (full 32-bit compare).
REQ-028: A JAL SHALL never be mispredicted.
REQ-029: On a misprediction, mispredicted=1 and flush_ptr=commit_ras_ptr.
REQ-030: pc_update SHALL be commit_target when the instruction is taken (branch taken, JAL, or JALR) and commit_pc+4 otherwise; the sum is mod 2^32, with wrap at 0xFFFFFFFC giving 0x00000000.
REQ-031: When commit_exception=1, the handshake SHALL complete with no valid_in, no mispredicted pulse, and no counter change; the trap path owns the redirect.
REQ-032: The FSM SHALL have states IDLE and FLUSH; commit_ready=1 only in IDLE.
REQ-033: A mispredicted handshake in IDLE SHALL move the FSM to FLUSH and load the flush counter with FLUSH_CYCLES.
REQ-034: In FLUSH, the flush counter SHALL decrement each cycle, and the FSM SHALL return to IDLE in the cycle the counter reaches 1, so commit_ready is low for exactly FLUSH_CYCLES cycles starting the cycle after the handshake.
REQ-035: Handshakes of non-mispredicted instructions in consecutive IDLE cycles SHALL be accepted back-to-back at full throughput.
REQ-036: branch_count SHALL increment on every non-exception handshake whose class is branch, JAL or JALR.
REQ-037: mispredict_count SHALL increment on every mispredicted handshake.
REQ-038: Both counters SHALL saturate at all-ones and never wrap.
REQ-039: If more than one class flag is set, priority SHALL be jalr > jump > branch.

Reset
REQ-040: Reset SHALL force the FSM to IDLE, clear the flush counter and both counters, and drive update=0, valid_in=0, mispredicted=0, committed_pc=0, pc_update=0 and flush_ptr=0.
REQ-041: commit_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-042: A reset asserted during FLUSH SHALL abort the flush immediately.
REQ-043: A reset asserted in the same cycle as a handshake SHALL discard that handshake.

Verification
REQ-044: Branch pc=0x100, prediction=1, taken=1 -> next cycle valid_in=1, update=1, committed_pc=0x100, mispredicted=0, branch_count=1.
REQ-045: Branch pc=0x200, prediction=1, taken=0, ras_ptr=5 -> mispredicted=1, pc_update=0x204, flush_ptr=5; commit_ready low for 2 cycles, then high.
REQ-046: JALR with commit_jalr_address=0x400 and commit_target=0x480 -> mispredicted=1, pc_update=0x480, valid_in=0; the same instruction with matching addresses gives no pulse.
REQ-047: Mispredicted branch with commit_exception=1 -> no pulses, counters unchanged, commit_ready stays 1.
REQ-048: Reset pulsed 1 cycle after a misprediction -> commit_ready=1 the cycle after reset, all outputs 0.
REQ-049: Preload both counters near saturation (CNT_W=4), then apply 20 mispredicted branches -> both counters hold 0xF.
